// File: rtl/slow_tick_bcd_counter.sv
// Multi-digit BCD event counter advanced by rising edges of a synchronised slow clock.
// Optional down-counting (down port, borrow logic) is built only when COUNT_DOWN_EN is defined.
module slow_tick_bcd_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  slow_clk,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
`ifdef COUNT_DOWN_EN
  input  logic                  down,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  step,
  output logic                  wrap
);

  localparam int W      = 4 * DIGITS;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   prev;
  logic                   armed;
  logic [FILL_W-1:0]      fill;
  logic                   tick;

  logic [W-1:0]           count_d;
  logic                   step_d;
  logic                   wrap_d;
  logic [W:0]             inc_res;
  logic [W-1:0]           load_clean;
  logic                   count_down;

  // Increment with per-digit carry; MSB of the result is the carry out of the top digit.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic         c;
    logic [3:0]   d;
    logic [W-1:0] r;
    c = 1'b1;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

`ifdef COUNT_DOWN_EN
  // Decrement with per-digit borrow; MSB of the result is the borrow out of the top digit.
  function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
    logic         b;
    logic [3:0]   d;
    logic [W-1:0] r;
    b = 1'b1;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  logic [W:0] dec_res;
  assign dec_res    = bcd_dec(count);
  assign count_down = down;
`else
  assign count_down = 1'b0;
`endif

  function automatic logic [W-1:0] bcd_clean(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  assign sync_out   = sync[SYNC_STAGES-1];
  assign tick       = armed & sync_out & ~prev;
  assign inc_res    = bcd_inc(count);
  assign load_clean = bcd_clean(load_value);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_clk};
      prev <= sync_out;
    end
  end

  // The synchroniser's reset zeros are not real samples of slow_clk, so arming waits
  // until the chain has been refilled before trusting a low output.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      fill  <= FILL_W'(SYNC_STAGES);
      armed <= 1'b0;
    end else begin
      if (fill != '0) fill <= fill - 1'b1;
      if (fill == '0 && !sync_out) armed <= 1'b1;
    end
  end

  always_comb begin
    count_d = count;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clean;
    end else if (tick && run) begin
      step_d = 1'b1;
`ifdef COUNT_DOWN_EN
      if (count_down) begin
        count_d = dec_res[W-1:0];
        wrap_d  = dec_res[W];
      end else begin
        count_d = inc_res[W-1:0];
        wrap_d  = inc_res[W];
      end
`else
      count_d = inc_res[W-1:0];
      wrap_d  = inc_res[W] | count_down;
`endif
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      step  <= step_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Scoreboard bench for slow_tick_bcd_counter: stimulus queues expected {wrap,count} per step,
// a negedge monitor pops and compares on every step pulse.
module tb_slow_tick_bcd_counter;

  logic        clock_in;
  logic        reset_n;
  logic        slow_clk;
  logic        run;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        down;
  logic [15:0] count;
  logic        step;
  logic        wrap;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic        prev_step = 1'b0;

  slow_tick_bcd_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clk   (slow_clk),
    .run        (run),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
`ifdef COUNT_DOWN_EN
    .down       (down),
`endif
    .count      (count),
    .step       (step),
    .wrap       (wrap)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clock_in) begin
    if (!reset_n) begin
      prev_step = 1'b0;
    end else begin
      if (step) begin
        if (prev_step) cmp("step_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          cmp("unexpected_step", {16'd0, count}, 32'hFFFF_FFFF);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          cmp("step_count", {16'd0, count}, {16'd0, e[15:0]});
          cmp("step_wrap", {31'd0, wrap}, {31'd0, e[16]});
        end
      end else if (wrap) begin
        cmp("wrap_without_step", 32'd1, 32'd0);
      end
      prev_step = step;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic check_now(input string name, input logic [15:0] c, input logic s);
    @(negedge clock_in);
    cmp({name, "_count"}, {16'd0, count}, {16'd0, c});
    cmp({name, "_step"}, {31'd0, step}, {31'd0, s});
  endtask

  task automatic push(input logic [15:0] c, input logic w);
    exp_q.push_back({w, c});
  endtask

  task automatic edge_once();
    slow_clk = 1'b1;
    cyc(4);
    slow_clk = 1'b0;
    cyc(4);
  endtask

  task automatic load_v(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    cyc(1);
    load       = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    slow_clk   = 1'b1;
    run        = 1'b1;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = 16'h0000;
    down       = 1'b0;
    cyc(3);
    check_now("reset", 16'h0000, 1'b0);
    cmp("reset_wrap", {31'd0, wrap}, 32'd0);

    // slow_clk held high through reset release must not tick
    cyc(1);
    reset_n = 1'b1;
    cyc(10);
    slow_clk = 1'b0;
    cyc(4);
    push(16'h0001, 1'b0);
    slow_clk = 1'b1;
    cyc(2);
    check_now("latency_e2", 16'h0000, 1'b0);
    check_now("latency_e3", 16'h0001, 1'b1);
    cyc(3);
    slow_clk = 1'b0;
    cyc(4);

    // up wrap
    load_v(16'h9998);
    check_now("load_9998", 16'h9998, 1'b0);
    push(16'h9999, 1'b0);
    edge_once();
    push(16'h0000, 1'b1);
    edge_once();
    check_now("after_wrap", 16'h0000, 1'b0);

    // invalid digit sanitised on load
    load_v(16'h12A4);
    check_now("load_12a4", 16'h1204, 1'b0);

    // tick, clear and load in the same cycle
    load_v(16'h0500);
    slow_clk = 1'b1;
    cyc(2);
    clear = 1'b1; load = 1'b1; load_value = 16'h3333;
    cyc(1);
    clear = 1'b0; load = 1'b0;
    check_now("tick_clr_ld", 16'h0000, 1'b0);
    cyc(2);
    slow_clk = 1'b0;
    cyc(4);

    // tick and load in the same cycle
    load_v(16'h0500);
    slow_clk = 1'b1;
    cyc(2);
    load = 1'b1; load_value = 16'h4321;
    cyc(1);
    load = 1'b0;
    check_now("tick_ld", 16'h4321, 1'b0);
    cyc(2);
    slow_clk = 1'b0;
    cyc(4);

    // run=0 ignores ticks; long high phase gives one step
    load_v(16'h0042);
    run = 1'b0;
    repeat (5) edge_once();
    check_now("run0_hold", 16'h0042, 1'b0);
    run = 1'b1;
    push(16'h0043, 1'b0);
    slow_clk = 1'b1;
    cyc(50);
    slow_clk = 1'b0;
    cyc(4);
    check_now("long_high", 16'h0043, 1'b0);

`ifdef COUNT_DOWN_EN
    down = 1'b1;
    load_v(16'h1000);
    push(16'h0999, 1'b0);
    edge_once();
    check_now("down_1000", 16'h0999, 1'b0);
    load_v(16'h0000);
    push(16'h9999, 1'b1);
    edge_once();
    check_now("down_wrap", 16'h9999, 1'b0);
    down = 1'b0;
`endif

    // asynchronous reset mid-run, then re-arm
    load_v(16'h0005);
    push(16'h0006, 1'b0);
    slow_clk = 1'b1;
    cyc(4);
    reset_n = 1'b0;
    #2;
    cmp("async_rst_count", {16'd0, count}, 32'd0);
    cmp("async_rst_step", {31'd0, step}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(6);
    slow_clk = 1'b0;
    cyc(4);
    push(16'h0001, 1'b0);
    edge_once();
    check_now("rearm", 16'h0001, 1'b0);

    cyc(5);
    cmp("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slow_tick_bcd_counter.md
# slow_tick_bcd_counter

Multi-digit BCD event counter clocked by the fast board clock. It advances once per rising edge of the divided slow clock produced by the clock-divider stage. The slow clock is treated as an asynchronous level: it is synchronised and edge-detected, never used as a clock. The BCD count feeds the display stage downstream, with single-cycle step and wrap pulses for sequencing logic.

## Interface
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS
- SYNC_STAGES, 2, flops in the slow_clk synchroniser (minimum 2)

- clock_in  input  1  system clock; all state on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- slow_clk  input  1  divided clock from the divider stage, sampled as data
- run  input  1  1 = ticks advance the count; 0 = ticks ignored
- clear  input  1  synchronous clear of the count to all-zero
- load  input  1  synchronous load of load_value
- load_value  input  4*DIGITS  BCD value for load; digit 0 in bits [3:0]
- down  input  1  1 = decrement, 0 = increment; present only with COUNT_DOWN_EN
- count  output  4*DIGITS  current BCD count, registered
- step  output  1  one-cycle pulse in the cycle count changed due to a tick
- wrap  output  1  one-cycle pulse when a tick wraps the count past its limit

## Operation
- Synchroniser: SYNC_STAGES flops on slow_clk, followed by a prev flop. An internal tick is asserted for one cycle when the synchroniser output is 1 and prev is 0.
- Arming:
  - Set when the synchroniser output is first seen at 0 after reset.
  - Ticks are suppressed until armed, so a slow_clk held high through reset release never produces a tick.
- Priority per cycle is clear > load > tick. Lower-priority events in the same cycle are dropped, not deferred.
- clear: count goes to 0. step and wrap stay 0.
- load:
  - Each digit of load_value is loaded.
  - Any digit above 9 loads as 0.
  - step and wrap stay 0.
- tick with run=1:
  - Increment or decrement with per-digit BCD carry or borrow.
  - Up: 9 becomes 0 and carries into the next digit.
  - Down: 0 becomes 9 and borrows from the next digit.
  - Wrap up: all 9s becomes all 0s, with wrap=1.
  - Wrap down: all 0s becomes all 9s, with wrap=1.
  - step=1 on every counted tick.
- tick with run=0: dropped; count holds and step stays 0.
- Reset values, all asynchronous on reset_n low: count=0, step=0, wrap=0, synchroniser=0, prev=0, armed=0.
- Reset asserted mid-operation clears everything immediately. Counting resumes only after re-arming.

## Timing
- Tick latency: count updates on rising edge SYNC_STAGES+1 after the first clock_in edge that samples slow_clk high. With the default of 2, this is the 3rd edge.
- step and wrap are registered and asserted in the same cycle that the new count appears. Each is high for exactly one clock_in cycle.
- Exactly one tick per slow_clk rising edge, however long slow_clk stays high. No tick on the falling edge.
- slow_clk high and low phases must each last at least 2 clock_in cycles for every edge to be counted. The block is not required to count shorter pulses.
- clear and load take effect on the next rising edge. There is no latency through the synchroniser for these inputs.

## Configuration
- COUNT_DOWN_EN defined:
  - The down port exists.
  - down is sampled in the tick cycle and selects decrement or increment.
- COUNT_DOWN_EN undefined:
  - No down port.
  - The counter is increment-only, and the borrow logic is not synthesised.

## Test plan
- Reset release with slow_clk held high for 10 cycles, then low, then high: no step during the held-high period. The first step follows the later rising edge, and count=0001.
- DIGITS=4, load 9998, run=1, 2 slow_clk edges: count goes 9999 then 0000. wrap=1 only on the second step. Each step is exactly one cycle wide.
- load_value 0x12A4 with load=1: count reads 0x1204 and step=0.
- Tick, clear and load all arriving in the same cycle: count=0 with no step. Tick and load in the same cycle without clear: count=load_value with no step.
- run=0 across 5 slow_clk edges starting from count 0042: count stays 0042 and step stays 0. With run=1 and slow_clk high for 50 cycles, count becomes 0043 with exactly one step.
- COUNT_DOWN_EN, down=1, count 1000, one edge: count=0999 with wrap=0. Then load 0000 and one edge: count=9999 with wrap=1. reset_n pulsed low mid-run: count reads 0 immediately.
